fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, the prefetch FIFO entry count (power of two, >=2).
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port redirect_valid  in  1  a taken branch/jump from execute; flushes and restarts fetch.
REQ-006 The block SHALL have port redirect_pc  in  32  the new fetch address; bits [1:0] are forced to 0.
REQ-007 The block SHALL have port mem_req_valid  out  1  the instruction memory read request.
REQ-008 The block SHALL have port mem_req_addr  out  32  the word-aligned request address.
REQ-009 The block SHALL have port mem_req_ready  in  1  memory accepts the request when high together with mem_req_valid.
REQ-010 The block SHALL have port mem_resp_valid  in  1  read data returned, in order, no earlier than 1 cycle after acceptance.
REQ-011 The block SHALL have port mem_resp_data  in  32  the instruction word.
REQ-012 The block SHALL have port inst_valid  out  1  an instruction is available to decode.
REQ-013 The block SHALL have port inst_data  out  32  the instruction word at the FIFO head.
REQ-014 The block SHALL have port inst_pc  out  32  the address of inst_data.
REQ-015 The block SHALL have port inst_ready  in  1  decode consumes the head when high together with inst_valid.

Function
REQ-016 The block SHALL hold at most one outstanding memory request at a time.
REQ-017 The block SHALL use states FETCH (mem_req_valid=1), WAIT (request accepted, awaiting response) and DROP (awaiting a response to discard).
REQ-018 The block SHALL assert mem_req_valid in FETCH only while fifo_count < DEPTH, and SHALL hold mem_req_valid and mem_req_addr stable until accepted.
REQ-019 On acceptance in FETCH, the block SHALL go to WAIT, record req_pc = fetch_pc, and set fetch_pc = fetch_pc + 4, wrapping modulo 2^32.
REQ-020 In WAIT, on mem_resp_valid, the block SHALL push {req_pc, mem_resp_data} into the FIFO and return to FETCH.
REQ-021 In DROP, on mem_resp_valid, the block SHALL discard the data, push nothing, and return to FETCH.
REQ-022 The block SHALL drive inst_valid = (fifo_count != 0), with inst_data/inst_pc taken from the head; the head is popped on inst_valid && inst_ready.
REQ-023 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push SHALL never occur into a full FIFO, which the outstanding-request rule of REQ-018 guarantees.
REQ-024 Fetch-to-decode latency SHALL be: request accepted in cycle N, response in cycle M>N, inst_valid high in cycle M+1.
REQ-025 On redirect_valid, the block SHALL empty the FIFO and set fetch_pc = {redirect_pc[31:2],2'b00}.
REQ-026 On redirect_valid, the next state SHALL be DROP if a response is outstanding and not arriving this cycle, otherwise FETCH.
REQ-027 On redirect_valid, a response arriving in the same cycle SHALL be discarded.
REQ-028 On redirect_valid, a request being accepted in the same cycle SHALL be treated as outstanding and go to DROP.
REQ-029 A pop coinciding with redirect_valid SHALL complete, and the flush SHALL take precedence for FIFO state.
REQ-030 inst_valid SHALL be 0 in the cycle after a redirect.
REQ-031 The first request after a redirect SHALL use the new address: in the following cycle if no response is pending, otherwise the cycle after the discarded response.
REQ-032 mem_req_valid SHALL be low in DROP and WAIT.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL set state=FETCH, fetch_pc=RESET_PC, fifo_count=0 and the FIFO pointers to 0.
REQ-034 The outputs SHALL read mem_req_valid=0, inst_valid=0, mem_req_addr=RESET_PC, inst_data=0 and inst_pc=0 in the cycle following a reset edge, with mem_req_valid rising in that same cycle.
REQ-035 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response after reset deasserts is outside contract, and memory SHALL be reset alongside.

Structure
REQ-036 RESET_PC default, instruction width (32) and the ebreak encoding 32'h0010_0073 SHALL live in the shared core package, and the state enum SHALL be local.
REQ-037 The block SHALL instantiate one sub-module, fetch_fifo (parameterised DEPTH, 64-bit entries {pc,inst}, push/pop/flush, count output).

Verification
REQ-038 The bench SHALL check reset: with memory always ready and 1-cycle latency, inst_pc sequence = 8000_0000, 8000_0004, 8000_0008 with inst_ready=1.
REQ-039 The bench SHALL check backpressure: inst_ready=0 for 20 cycles, after which the FIFO holds exactly 4 entries, mem_req_valid=0, and releasing gives 4 in-order pcs with no gaps.
REQ-040 The bench SHALL check redirect with pending response: redirect_pc=0x8000_0102 while WAIT with 3-cycle latency; the stale word is dropped, the next mem_req_addr is 0x8000_0100, and the first inst_pc after is 0x8000_0100.
REQ-041 The bench SHALL check redirect coinciding with mem_resp_valid and a pop: the popped instruction is consumed once, the response is discarded, and inst_valid=0 in the next cycle.
REQ-042 The bench SHALL check stalls: mem_req_ready toggled randomly, with mem_req_addr stable while valid&&!ready and no duplicate or skipped pc.
REQ-043 The bench SHALL check wrap-around: redirect to 0xFFFF_FFFC; the following fetch addresses are 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared core definitions for the instruction fetch slice.
//   XLEN / INST_W     : address and instruction word widths
//   RESET_PC_DEFAULT  : first fetch address after reset
//   EBREAK_INST       : ebreak encoding, kept here for the rest of the core
//   fetch_entry_t     : one prefetch FIFO entry {pc, inst}
//   word_align()      : clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INST_W-1:0] EBREAK_INST      = 32'h0010_0073;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundles the fetch unit's redirect, memory and decode
// handshakes.
//   master : the fetch unit (drives mem_req_*, inst_valid/data/pc)
//   slave  : the surroundings (execute redirect, instruction memory, decode)
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              mem_req_valid;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [INST_W-1:0] mem_resp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
           mem_resp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
           mem_resp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- prefetch queue of {pc, inst} entries between fetch and decode.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the queue; wins over push/pop in the same cycle
//   push       : writes push_data at the tail (caller never pushes when full)
//   pop        : drops the head (caller never pops when empty)
//   head       : entry at the head of the queue
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) store_q[wr_ptr] <= push_data;
  end

  assign head = store_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch with a single outstanding memory request
// and a DEPTH-entry prefetch FIFO toward decode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master
//              redirect_valid/pc     : flush and restart fetch at a new pc
//              mem_req_valid/addr/ready : instruction read request
//              mem_resp_valid/data   : in-order read data
//              inst_valid/data/pc/ready : decode-side FIFO head
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic             req_fire;
  logic             push, pop, flush;
  fetch_entry_t     push_data, head;
  logic [CNT_W-1:0] count;

  // Requests are only offered while the FIFO can absorb the reply, which is
  // what keeps the single outstanding response from overflowing it.
  assign bus.mem_req_valid = (state_q == FETCH) && (count < FULL_COUNT) && !rst;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = bus.inst_valid ? head.inst : '0;
  assign bus.inst_pc    = bus.inst_valid ? head.pc   : '0;
  assign pop            = bus.inst_valid && bus.inst_ready;

  assign push_data = '{pc: req_pc_q, inst: bus.mem_resp_data};

  // A redirect overrides everything: the FIFO is flushed, and if a reply is
  // still owed (including one for a request accepted this very cycle) it
  // must be swallowed in DROP before fetching from the new pc.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_d = word_align(bus.redirect_pc);
      if ((state_q == FETCH && req_fire) ||
          (state_q != FETCH && !bus.mem_resp_valid))
        state_d = DROP;
      else
        state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (req_fire) begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            push    = 1'b1;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (bus.mem_resp_valid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit. A behavioural memory
// and an expected-instruction queue run alongside the DUT; each scenario task
// drives stimulus and compares what it observes.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural instruction memory: one request in flight, reply after a
  // chosen number of cycles.
  logic        mem_pending;
  int          mem_wait;
  logic [31:0] mem_addr;
  logic        mem_stale;
  int          latency;
  bit          rand_lat;
  int          ready_mode;
  bit          rand_inst_ready;

  // Reference: instructions decode should see, and next expected fetch pc.
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch_pc;

  logic [31:0] pop_log[$];
  logic [31:0] acc_log[$];
  int          diff_cnt;
  string       diff_msg;
  logic        stalled_prev;
  logic [31:0] stalled_addr;
  int          stall_viol;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hC3A5_5A3C) + 32'h0000_0101;
  endfunction

  task automatic note_diff(input string m);
    if (diff_cnt == 0) diff_msg = m;
    diff_cnt++;
  endtask

  // One clock cycle: drive memory inputs, compare DUT against the reference,
  // cross the edge, then advance memory and reference.
  task automatic tick();
    logic acc, pop, resp, redir, exp_rv;
    logic [31:0] addr, rpc;
    bus.mem_resp_valid = mem_pending && (mem_wait == 1);
    bus.mem_resp_data  = bus.mem_resp_valid ? word_of(mem_addr) : 32'h0;
    case (ready_mode)
      0:       bus.mem_req_ready = 1'b1;
      1:       bus.mem_req_ready = 1'($urandom_range(0, 1));
      default: bus.mem_req_ready = 1'b0;
    endcase
    if (rand_inst_ready) bus.inst_ready = 1'($urandom_range(0, 1));
    #1;
    exp_rv = !mem_pending && (exp_q.size() < DEPTH);
    if (bus.mem_req_valid !== exp_rv)
      note_diff($sformatf("mem_req_valid=%b model=%b t=%0t", bus.mem_req_valid, exp_rv, $time));
    if (bus.mem_req_valid && bus.mem_req_addr !== exp_fetch_pc)
      note_diff($sformatf("mem_req_addr=%h model=%h t=%0t", bus.mem_req_addr, exp_fetch_pc, $time));
    if (bus.inst_valid !== (exp_q.size() != 0))
      note_diff($sformatf("inst_valid=%b model_entries=%0d t=%0t", bus.inst_valid, exp_q.size(), $time));
    if (exp_q.size() != 0 && {bus.inst_pc, bus.inst_data} !== exp_q[0])
      note_diff($sformatf("head=%h model=%h t=%0t", {bus.inst_pc, bus.inst_data}, exp_q[0], $time));
    if (stalled_prev && !(bus.mem_req_valid && bus.mem_req_addr == stalled_addr)) stall_viol++;
    acc   = bus.mem_req_valid && bus.mem_req_ready;
    pop   = bus.inst_valid && bus.inst_ready;
    resp  = bus.mem_resp_valid;
    redir = bus.redirect_valid;
    addr  = bus.mem_req_addr;
    rpc   = {bus.redirect_pc[31:2], 2'b00};
    if (pop) pop_log.push_back(bus.inst_pc);
    if (acc) acc_log.push_back(addr);
    stalled_prev = bus.mem_req_valid && !bus.mem_req_ready && !redir;
    stalled_addr = addr;
    @(posedge clk);
    #1;
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (resp) begin
      if (!mem_stale && !redir) exp_q.push_back({mem_addr, word_of(mem_addr)});
      mem_pending = 1'b0;
    end else if (mem_pending) begin
      mem_wait--;
    end
    if (acc) begin
      mem_pending  = 1'b1;
      mem_wait     = rand_lat ? int'($urandom_range(1, 3)) : latency;
      mem_addr     = addr;
      mem_stale    = 1'b0;
      exp_fetch_pc = addr + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      if (mem_pending) mem_stale = 1'b1;
      exp_fetch_pc = rpc;
    end
  endtask

  // Reset DUT and memory together and return the bench to default modes.
  task automatic applyStimulus_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
    mem_pending = 1'b0; mem_wait = 0; mem_addr = 32'h0; mem_stale = 1'b0;
    latency = 1; rand_lat = 1'b0; ready_mode = 0; rand_inst_ready = 1'b0;
    exp_q.delete(); exp_fetch_pc = RESET_PC;
    pop_log.delete(); acc_log.delete();
    diff_cnt = 0; diff_msg = ""; stalled_prev = 1'b0; stalled_addr = 32'h0; stall_viol = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus_reset();
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.mem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_req_addr: got %h want %h", bus.mem_req_addr, RESET_PC); end
    checks++; if (bus.inst_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_data: got %h want 0", bus.inst_data); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_req_valid: got %b want 1", bus.mem_req_valid); end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 30 && pop_log.size() < 3; i++) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("[TB] FAIL reset_seq[%0d]: got %h (pops=%0d) want %h", i,
                 (pop_log.size() > i) ? pop_log[i] : 32'hx, pop_log.size(), RESET_PC + 32'(4 * i));
      end
    end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL reset_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  task automatic test_backpressure();
    applyStimulus_reset();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_inst_valid: got %b want 1", bus.inst_valid); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid_full: got %b want 0", bus.mem_req_valid); end
    ready_mode = 2;
    pop_log.delete();
    bus.inst_ready = 1'b1;
    repeat (6) tick();
    checks++; if (pop_log.size() !== 4) begin errors++; $display("[TB] FAIL bp_entries: got %0d want 4", pop_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("[TB] FAIL bp_order[%0d]: got %h want %h", i,
                 (pop_log.size() > i) ? pop_log[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b want 0", bus.inst_valid); end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL bp_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  task automatic test_redirect_pending();
    bit found;
    applyStimulus_reset();
    rst = 1'b0;
    latency = 3;
    bus.inst_ready = 1'b1;
    repeat (6) tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_pending && mem_wait > 1) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rp_wait_timeout: got no WAIT window want one"); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    tick();
    bus.redirect_valid = 1'b0;
    acc_log.delete(); pop_log.delete();
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rp_inst_valid_after: got %b want 0", bus.inst_valid); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rp_drop_req_valid: got %b want 0", bus.mem_req_valid); end
    for (int i = 0; i < 40 && pop_log.size() < 1; i++) tick();
    checks++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h8000_0100) begin
      errors++; $display("[TB] FAIL rp_first_addr: got %h want 80000100", (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    end
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h8000_0100) begin
      errors++; $display("[TB] FAIL rp_first_pc: got %h want 80000100", (pop_log.size() > 0) ? pop_log[0] : 32'hx);
    end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL rp_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  task automatic test_redirect_resp_pop();
    bit found;
    int n;
    logic [31:0] head_pc;
    applyStimulus_reset();
    rst = 1'b0;
    latency = 2;
    repeat (4) tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid && mem_pending && mem_wait == 1) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rrp_window_timeout: got no coincidence want one"); end
    head_pc = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'hx;
    n = pop_log.size();
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (pop_log.size() !== n + 1) begin errors++; $display("[TB] FAIL rrp_pop_count: got %0d want %0d", pop_log.size(), n + 1); end
    checks++;
    if (pop_log.size() <= n || pop_log[n] !== head_pc) begin
      errors++; $display("[TB] FAIL rrp_popped_pc: got %h want %h", (pop_log.size() > n) ? pop_log[n] : 32'hx, head_pc);
    end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rrp_inst_valid_after: got %b want 0", bus.inst_valid); end
    for (int i = 0; i < 20 && pop_log.size() <= n + 1; i++) tick();
    checks++;
    if (pop_log.size() <= n + 1 || pop_log[n+1] !== 32'h0000_1000) begin
      errors++; $display("[TB] FAIL rrp_next_pc: got %h want 00001000", (pop_log.size() > n + 1) ? pop_log[n+1] : 32'hx);
    end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL rrp_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  task automatic test_stalls();
    int bad_pop, bad_acc;
    applyStimulus_reset();
    rst = 1'b0;
    ready_mode      = 1;
    rand_lat        = 1'b1;
    rand_inst_ready = 1'b1;
    repeat (300) tick();
    rand_inst_ready = 1'b0;
    bad_pop = 0; bad_acc = 0;
    foreach (pop_log[i]) if (pop_log[i] !== RESET_PC + 32'(4 * i)) bad_pop++;
    foreach (acc_log[i]) if (acc_log[i] !== RESET_PC + 32'(4 * i)) bad_acc++;
    checks++; if (stall_viol !== 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); end
    checks++; if (pop_log.size() < 10) begin errors++; $display("[TB] FAIL stall_progress: got %0d pops want >=10", pop_log.size()); end
    checks++; if (bad_pop !== 0) begin errors++; $display("[TB] FAIL stall_pop_seq: got %0d out-of-order pcs want 0", bad_pop); end
    checks++; if (bad_acc !== 0) begin errors++; $display("[TB] FAIL stall_req_seq: got %0d out-of-order addrs want 0", bad_acc); end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL stall_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  task automatic test_wrap();
    applyStimulus_reset();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 30 && (acc_log.size() < 2 || pop_log.size() < 2); i++) tick();
    checks++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_addr0: got %h want fffffffc", (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    end
    checks++;
    if (acc_log.size() < 2 || acc_log[1] !== 32'h0000_0000) begin
      errors++; $display("[TB] FAIL wrap_addr1: got %h want 00000000", (acc_log.size() > 1) ? acc_log[1] : 32'hx);
    end
    checks++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_pcs: got %h,%h want fffffffc,00000000",
                         (pop_log.size() > 0) ? pop_log[0] : 32'hx, (pop_log.size() > 1) ? pop_log[1] : 32'hx);
    end
    checks++; if (diff_cnt !== 0) begin errors++; $display("[TB] FAIL wrap_model: %0d diffs, first: %s", diff_cnt, diff_msg); end
  endtask

  // Scenario sequence and the final summary.
  initial begin
    rst = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect_pending();
    test_redirect_resp_pop();
    test_stalls();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
